go_board_ctrl: RTL
==================

Name: go_board_ctrl

Overview:
- Owns the authoritative 9x9 Go board state and is the writer side of the board interface that the VGA board renderer reads.
- Turns debounced button levels into cursor moves, stone placements and passes, alternating black/white.
- Exposes a registered random-access read port that the renderer indexes by (row, col).
- Sits between the debounce instances and the renderer in the 65 MHz video clock domain.

Parameters:
- BOARD_N, 9, board edge length; cell index = row*BOARD_N+col.
- MOVE_W, 7, width of move counter.

Ports:
- vclock_in  in  1  system clock (65 MHz).
- reset_in  in  1  synchronous, active-high reset.
- up_in, down_in, left_in, right_in  in  1 each  debounced level inputs; rising edge = one cursor step.
- place_in  in  1  debounced level; rising edge = place stone at cursor.
- pass_in  in  1  debounced level; rising edge = pass turn.
- rd_row_in, rd_col_in  in  4 each  read address.
- rd_state_out  out  2  cell at read address, 1-cycle latency: 00 empty, 01 black, 10 white.
- cursor_row_out, cursor_col_out  out  4 each  current cursor.
- turn_out  out  1  0 = black to move, 1 = white.
- place_ok_out, place_err_out  out  1 each  one-cycle result pulses.
- move_count_out  out  MOVE_W  stones placed since reset.
- clearing_out  out  1  high while board is being cleared.
- game_over_out  out  1  two consecutive passes seen.

Behaviour:
- Storage: 81 x 2-bit array. One write port (internal). One read port (rd_*), registered.
- Read port: address with rd_row_in>8 or rd_col_in>8 returns 00. Same-cycle read and write of the same cell returns the old value.
- Edge detect: each button input has a registered previous value. An edge is in_level & ~prev. prev registers reset to 0.
- Reset: state=CLEAR, clear index=0, cursor=(4,4), turn_out=0, move_count_out=0, pulses=0, game_over_out=0, pass count=0, rd_state_out=00.
- FSM states:
  - CLEAR: writes 00 to cell idx each cycle for 81 cycles (idx 0..80). clearing_out=1. All edges ignored. After idx 80 is written, next state is IDLE. IDLE is entered 81 cycles after reset deasserts.
  - IDLE, priority order: game_over_out set > place edge > pass edge > direction edges.
    - game_over_out set: all edges ignored.
    - Place edge: latch cursor and turn, go to CHECK. Direction and pass edges in the same cycle are dropped.
    - Pass edge: toggle turn, increment pass count. When pass count reaches 2, set game_over_out (sticky until reset). Direction edges in the same cycle still apply.
    - Direction edges: up decrements row, down increments row, left decrements col, right increments col. Vertical and horizontal moves apply independently. If up and down arrive together there is no row change; left and right together give no col change.
    - Edge of board (macro absent): cursor saturates at 0 and 8.
  - CHECK: reads the latched cell. If it is empty, go to WRITE; otherwise go to REJECT. Edges ignored.
  - WRITE: writes 01 (turn=0) or 10 (turn=1). place_ok_out=1 for this cycle. Toggles turn, increments move_count_out (saturates at all-ones), clears pass count. Returns to IDLE.
  - REJECT: place_err_out=1 for this cycle. Board, turn and count unchanged. Returns to IDLE.
- Latency: if the place edge is seen at cycle N, the result pulse and the cell write occur at N+2. The new value is visible on rd_state_out at N+3 if addressed.
- Reset asserted in any state, including mid-CLEAR or WRITE: restarts CLEAR on the next cycle; a pending write is discarded.
- Levels held high produce exactly one action; no auto-repeat.

Optional Feature:
- GO_CURSOR_WRAP_EN:
  - Defined: cursor wraps at the board edge (up at row 0 goes to 8, right at col 8 goes to 0).
  - Undefined: cursor saturates at 0/8 and edges beyond the board are ignored.

Test Plan:
- Reset then clear:
  - Release reset, wait 81 cycles, read all 81 cells. Required: clearing_out high for exactly 81 cycles, every cell 00, cursor (4,4), turn 0.
- Placement alternation:
  - Pulse place at (4,4), move right, pulse place. Required: (4,4)=01, (4,5)=10, move_count_out=2, turn_out=0, place_ok_out pulses exactly 2 cycles after each edge.
- Occupied cell:
  - Place at (4,4) twice. Required: second attempt gives place_err_out pulse, cell stays 01, turn_out=1, move_count_out=1.
- Cursor edges:
  - From (0,0) press up and left. Required without macro: (0,0). With GO_CURSOR_WRAP_EN: (8,8).
  - Simultaneous up+down: row unchanged.
- Passes:
  - Pass, place, pass, pass. Required: game_over_out only after the final pass (the place clears the count).
  - Subsequent place edge: no pulse, board unchanged.
- Reset mid-operation:
  - Assert reset the cycle a place edge enters CHECK. Required: no place_ok_out, full clear replays, move_count_out=0.

Source files
------------

// File: rtl/go_board_ctrl.sv
// 9x9 Go board owner: button edges drive the cursor, placements and passes; the renderer reads cells by (row, col).
// Define GO_CURSOR_WRAP_EN to make the cursor wrap at the board edge instead of saturating.
module go_board_ctrl #(
    parameter int BOARD_N = 9,
    parameter int MOVE_W  = 7
) (
    input  logic              vclock_in,
    input  logic              reset_in,
    input  logic              up_in,
    input  logic              down_in,
    input  logic              left_in,
    input  logic              right_in,
    input  logic              place_in,
    input  logic              pass_in,
    input  logic [3:0]        rd_row_in,
    input  logic [3:0]        rd_col_in,
    output logic [1:0]        rd_state_out,
    output logic [3:0]        cursor_row_out,
    output logic [3:0]        cursor_col_out,
    output logic              turn_out,
    output logic              place_ok_out,
    output logic              place_err_out,
    output logic [MOVE_W-1:0] move_count_out,
    output logic              clearing_out,
    output logic              game_over_out
);
    localparam int         CELLS   = BOARD_N * BOARD_N;
    localparam int         IDX_W   = $clog2(CELLS);
    localparam logic [3:0] MAX_POS = 4'(BOARD_N - 1);
    localparam logic [3:0] MID_POS = 4'(BOARD_N / 2);
    localparam int B_UP = 5, B_DN = 4, B_LF = 3, B_RT = 2, B_PL = 1, B_PS = 0;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_CHECK, S_WRITE, S_REJECT} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    clr_idx_q;
    logic [3:0]          cursor_row_q, cursor_col_q;
    logic [3:0]          row_d, col_d;
    logic                turn_q, lat_turn_q;
    logic [IDX_W-1:0]    lat_idx_q;
    logic [MOVE_W-1:0]   move_count_q;
    logic [1:0]          pass_cnt_q;
    logic                place_ok_q, place_err_q, clearing_q, game_over_q;
    logic [5:0]          btn_prev_q, btn_level, btn_rise;
    logic [1:0]          board_q [0:CELLS-1];
    logic [1:0]          rd_state_q;
    logic                cell_empty, rd_in_range;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        cell_idx = IDX_W'(r) * IDX_W'(BOARD_N) + IDX_W'(c);
    endfunction

    function automatic logic [3:0] step_dec(input logic [3:0] p);
`ifdef GO_CURSOR_WRAP_EN
        step_dec = (p == 4'd0) ? MAX_POS : p - 4'd1;
`else
        step_dec = (p == 4'd0) ? 4'd0 : p - 4'd1;
`endif
    endfunction

    function automatic logic [3:0] step_inc(input logic [3:0] p);
`ifdef GO_CURSOR_WRAP_EN
        step_inc = (p == MAX_POS) ? 4'd0 : p + 4'd1;
`else
        step_inc = (p == MAX_POS) ? MAX_POS : p + 4'd1;
`endif
    endfunction

    assign btn_level   = {up_in, down_in, left_in, right_in, place_in, pass_in};
    assign btn_rise    = btn_level & ~btn_prev_q;
    assign cell_empty  = (board_q[lat_idx_q] == 2'b00);
    assign rd_in_range = (rd_row_in <= MAX_POS) && (rd_col_in <= MAX_POS);

    // Opposite directions arriving together cancel; rows and columns move independently.
    always_comb begin
        row_d = cursor_row_q;
        col_d = cursor_col_q;
        if (btn_rise[B_UP] && !btn_rise[B_DN]) row_d = step_dec(cursor_row_q);
        else if (btn_rise[B_DN] && !btn_rise[B_UP]) row_d = step_inc(cursor_row_q);
        if (btn_rise[B_LF] && !btn_rise[B_RT]) col_d = step_dec(cursor_col_q);
        else if (btn_rise[B_RT] && !btn_rise[B_LF]) col_d = step_inc(cursor_col_q);
    end

    always_ff @(posedge vclock_in) begin
        if (reset_in) begin
            state_q      <= S_CLEAR;
            clr_idx_q    <= '0;
            cursor_row_q <= MID_POS;
            cursor_col_q <= MID_POS;
            turn_q       <= 1'b0;
            move_count_q <= '0;
            pass_cnt_q   <= 2'd0;
            place_ok_q   <= 1'b0;
            place_err_q  <= 1'b0;
            clearing_q   <= 1'b1;
            game_over_q  <= 1'b0;
            btn_prev_q   <= '0;
        end else begin
            btn_prev_q  <= btn_level;
            place_ok_q  <= 1'b0;
            place_err_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IDX_W'(CELLS - 1)) begin
                        state_q    <= S_IDLE;
                        clearing_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (!game_over_q) begin
                        if (btn_rise[B_PL]) begin
                            lat_idx_q  <= cell_idx(cursor_row_q, cursor_col_q);
                            lat_turn_q <= turn_q;
                            state_q    <= S_CHECK;
                        end else begin
                            if (btn_rise[B_PS]) begin
                                turn_q     <= ~turn_q;
                                pass_cnt_q <= pass_cnt_q + 2'd1;
                                if (pass_cnt_q == 2'd1) game_over_q <= 1'b1;
                            end
                            cursor_row_q <= row_d;
                            cursor_col_q <= col_d;
                        end
                    end
                end
                S_CHECK: begin
                    if (cell_empty) begin
                        state_q    <= S_WRITE;
                        place_ok_q <= 1'b1;
                    end else begin
                        state_q     <= S_REJECT;
                        place_err_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    turn_q     <= ~lat_turn_q;
                    pass_cnt_q <= 2'd0;
                    if (move_count_q != '1) move_count_q <= move_count_q + 1'b1;
                    state_q    <= S_IDLE;
                end
                S_REJECT: state_q <= S_IDLE;
                default:  state_q <= S_CLEAR;
            endcase
        end
    end

    // The stone is committed as WRITE is entered so a reader sees it one cycle after the ok pulse.
    always_ff @(posedge vclock_in) begin
        if (!reset_in) begin
            if (state_q == S_CLEAR) board_q[clr_idx_q] <= 2'b00;
            else if (state_q == S_CHECK && cell_empty)
                board_q[lat_idx_q] <= lat_turn_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge vclock_in) begin
        if (reset_in) rd_state_q <= 2'b00;
        else          rd_state_q <= rd_in_range ? board_q[cell_idx(rd_row_in, rd_col_in)] : 2'b00;
    end

    assign rd_state_out   = rd_state_q;
    assign cursor_row_out = cursor_row_q;
    assign cursor_col_out = cursor_col_q;
    assign turn_out       = turn_q;
    assign place_ok_out   = place_ok_q;
    assign place_err_out  = place_err_q;
    assign move_count_out = move_count_q;
    assign clearing_out   = clearing_q;
    assign game_over_out  = game_over_q;
endmodule
